bist_session_controller: RTL and testbench

- Initiator/sequencer for the LFSR/MISR BIST wrapper. The wrapper is the responder; this block is the tester-side master that drives a test session against it.
- Accepts a start request, drives the wrapper's testmode and a synchronous clear into its LFSR/MISR, and waits for the wrapper's end-of-sequence flag.
- Captures the MISR signature, compares it against the golden value, and reports pass/fail/timeout with a one-cycle done pulse.
- Keeps a saturating count of failed sessions.

---
 rtl/bist_session_controller.sv | 135 +++++++++++++
 tb/tb_bist_session_controller.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bist_session_controller.sv
// Tester-side sequencer for the LFSR/MISR BIST wrapper: clears the wrapper, runs the
// pattern sequence, captures and grades the MISR signature, and tallies failed sessions.
module bist_session_controller #(
  parameter int                   SIG_WIDTH      = 4,
  parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG     = 4'b0011,
  parameter int                   CLEAR_CYCLES   = 1,
  parameter int                   TIMEOUT_CYCLES = 15,
  parameter int                   FAILCNT_WIDTH  = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     bist_finish,
  input  logic [SIG_WIDTH-1:0]     misr_sig,
  output logic                     bist_testmode,
  output logic                     bist_clear,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     fail,
  output logic                     timeout,
  output logic [SIG_WIDTH-1:0]     signature,
  output logic [FAILCNT_WIDTH-1:0] fail_count
);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    REPORT
  } state_t;

  localparam logic [7:0]               CLEAR_LAST   = 8'(CLEAR_CYCLES - 1);
  localparam logic [7:0]               TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [FAILCNT_WIDTH-1:0] FAILCNT_ONE  = FAILCNT_WIDTH'(1);

  state_t                   state, state_next;
  logic [7:0]               cnt, cnt_next;
  logic                     pass_next, fail_next, timeout_next;
  logic [SIG_WIDTH-1:0]     signature_next;
  logic [FAILCNT_WIDTH-1:0] fail_count_next;

  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    pass_next       = pass;
    fail_next       = fail;
    timeout_next    = timeout;
    signature_next  = signature;
    fail_count_next = fail_count;

    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_next   = CLEAR;
          cnt_next     = '0;
          pass_next    = 1'b0;
          fail_next    = 1'b0;
          timeout_next = 1'b0;
        end
      end

      CLEAR: begin
        if (abort) begin
          state_next = IDLE;
        end else if (cnt == CLEAR_LAST) begin
          state_next = RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end

      RUN: begin
        // Abort beats finish, and finish beats a timeout landing on the same edge.
        if (abort) begin
          state_next = IDLE;
        end else if (bist_finish) begin
          state_next     = REPORT;
          signature_next = misr_sig;
          pass_next      = (misr_sig == GOLDEN_SIG);
          fail_next      = (misr_sig != GOLDEN_SIG);
        end else if (cnt == TIMEOUT_LAST) begin
          state_next     = REPORT;
          signature_next = misr_sig;
          timeout_next   = 1'b1;
          fail_next      = 1'b1;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end

      REPORT: begin
        state_next = IDLE;
        if (fail && (fail_count != '1)) begin
          fail_count_next = fail_count + FAILCNT_ONE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they change on the same
  // edge as the state register while still coming straight from flops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      bist_testmode <= 1'b0;
      bist_clear    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail          <= 1'b0;
      timeout       <= 1'b0;
      signature     <= '0;
      fail_count    <= '0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      bist_testmode <= (state_next == CLEAR) || (state_next == RUN);
      bist_clear    <= (state_next == CLEAR);
      busy          <= (state_next != IDLE);
      done          <= (state_next == REPORT);
      pass          <= pass_next;
      fail          <= fail_next;
      timeout       <= timeout_next;
      signature     <= signature_next;
      fail_count    <= fail_count_next;
    end
  end

endmodule

// File: tb/tb_bist_session_controller.sv
// Randomized session-level bench for bist_session_controller; expected outcomes are derived
// from which event (abort, finish, timeout) occurs first in each generated session.
module tb_bist_session_controller;

  localparam int         TO     = 15;
  localparam int         CC     = 1;
  localparam logic [3:0] GOLDEN = 4'b0011;

  logic       clock = 1'b0;
  logic       reset, start, abort, bist_finish;
  logic [3:0] misr_sig;
  logic       bist_testmode, bist_clear, busy, done, pass, fail, timeout;
  logic [3:0] signature;
  logic [7:0] fail_count;
  logic [6:0] st;

  int compared   = 0;
  int mismatched = 0;
  int model_failcnt = 0;
  bit m_pass = 0, m_fail = 0, m_to = 0;

  bist_session_controller #(
    .SIG_WIDTH(4), .GOLDEN_SIG(4'b0011), .CLEAR_CYCLES(CC),
    .TIMEOUT_CYCLES(TO), .FAILCNT_WIDTH(8)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .bist_finish(bist_finish), .misr_sig(misr_sig),
    .bist_testmode(bist_testmode), .bist_clear(bist_clear), .busy(busy),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .signature(signature), .fail_count(fail_count)
  );

  always #5 clock = ~clock;

  assign st = {busy, bist_testmode, bist_clear, done, pass, fail, timeout};

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // finish_k/abort_k: RUN cycle (1-based) on which the event is sampled, 0 = never.
  task automatic run_session(input int finish_k, input logic [3:0] sig,
                             input int abort_k, input bit noise);
    int         end_k, kind;  // kind: 0 finish, 1 timeout, 2 abort
    logic [3:0] drv, exp_sig;
    logic [6:0] exp;
    bit         p, f, t;
    if (abort_k != 0 && abort_k <= TO && (finish_k == 0 || abort_k <= finish_k)) begin
      kind = 2; end_k = abort_k;
    end else if (finish_k != 0 && finish_k <= TO) begin
      kind = 0; end_k = finish_k;
    end else begin
      kind = 1; end_k = TO;
    end
    p = (kind == 0) && (sig == GOLDEN);
    f = (kind == 1) || ((kind == 0) && (sig != GOLDEN));
    t = (kind == 1);
    exp_sig = '0;

    start = 1'b1; abort = 1'b0; bist_finish = 1'b0; misr_sig = 4'($urandom);
    tick;
    start = 1'b0;
    m_pass = 0; m_fail = 0; m_to = 0;
    compared++;
    if (st !== 7'b1110000) begin
      mismatched++;
      $display("FAIL start_edge: status got %b want %b", st, 7'b1110000);
    end
    for (int j = 1; j <= CC; j++) begin
      tick;
      exp = (j < CC) ? 7'b1110000 : 7'b1100000;
      compared++;
      if (st !== exp) begin
        mismatched++;
        $display("FAIL clear_phase[%0d]: status got %b want %b", j, st, exp);
      end
    end
    for (int k = 1; k <= end_k; k++) begin
      abort       = (k == abort_k);
      bist_finish = (k == finish_k);
      drv         = (k == finish_k) ? sig : 4'($urandom);
      misr_sig    = drv;
      start       = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (k == end_k) exp_sig = drv;
      tick;
      if (k < end_k)      exp = 7'b1100000;
      else if (kind == 2) exp = 7'b0000000;
      else                exp = {1'b1, 1'b0, 1'b0, 1'b1, p, f, t};
      compared++;
      if (st !== exp) begin
        mismatched++;
        $display("FAIL run_cycle[%0d]: status got %b want %b", k, st, exp);
      end
      if (k == end_k && kind != 2) begin
        compared++;
        if (signature !== exp_sig) begin
          mismatched++;
          $display("FAIL signature: got %h want %h", signature, exp_sig);
        end
      end
    end
    abort = 1'b0; bist_finish = 1'b0;
    if (kind != 2) begin
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      tick;
      start = 1'b0;
      m_pass = p; m_fail = f; m_to = t;
      if (f && model_failcnt < 255) model_failcnt++;
      exp = {4'b0000, p, f, t};
      compared++;
      if (st !== exp) begin
        mismatched++;
        $display("FAIL report_exit: status got %b want %b", st, exp);
      end
    end
    compared++;
    if (fail_count !== 8'(model_failcnt)) begin
      mismatched++;
      $display("FAIL fail_count: got %0d want %0d", fail_count, model_failcnt);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; abort = 1'b0; bist_finish = 1'b0; misr_sig = '0;
    tick; tick;
    reset = 1'b0;
    tick;
    compared++;
    if ({st, signature, fail_count} !== '0) begin
      mismatched++;
      $display("FAIL reset_state: got %b/%h/%0d want all zero", st, signature, fail_count);
    end
  endtask

  task automatic test_pass_and_fault;
    run_session(8, GOLDEN, 0, 0);
    run_session(8, 4'b0101, 0, 0);
  endtask

  task automatic test_timeout;
    run_session(0, GOLDEN, 0, 0);   // never finishes
    run_session(15, GOLDEN, 0, 0);  // finish on the last allowed cycle wins
    run_session(15, 4'b1100, 0, 0);
    run_session(16, GOLDEN, 0, 0);  // finish too late
  endtask

  task automatic test_abort;
    logic [6:0] exp;
    run_session(8, GOLDEN, 3, 0);
    // abort while still clearing
    start = 1'b1;
    tick;
    start = 1'b0; abort = 1'b1;
    tick;
    abort = 1'b0;
    compared++;
    if (st !== 7'b0000000) begin
      mismatched++;
      $display("FAIL clear_abort: status got %b want %b", st, 7'b0000000);
    end
    m_pass = 0; m_fail = 0; m_to = 0;
    // start and abort together in IDLE: nothing happens, sticky flags untouched
    run_session(8, 4'b1111, 0, 0);
    start = 1'b1; abort = 1'b1;
    tick; tick;
    start = 1'b0; abort = 1'b0;
    exp = {4'b0000, m_pass, m_fail, m_to};
    compared++;
    if (st !== exp) begin
      mismatched++;
      $display("FAIL idle_start_abort: status got %b want %b", st, exp);
    end
  endtask

  task automatic test_start_during_run;
    run_session(8, GOLDEN, 0, 1);
    run_session(5, 4'b0110, 0, 1);
  endtask

  task automatic test_random;
    int         fk, ak;
    logic [3:0] s;
    for (int n = 0; n < 40; n++) begin
      fk = $urandom_range(0, 18);
      s  = ($urandom_range(0, 1) == 1) ? GOLDEN : 4'($urandom);
      ak = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 16) : 0;
      run_session(fk, s, ak, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_saturation;
    for (int n = 0; n < 256; n++) run_session(1, 4'b0101, 0, 0);
    compared++;
    if (fail_count !== 8'hFF) begin
      mismatched++;
      $display("FAIL saturation: got %h want %h", fail_count, 8'hFF);
    end
  endtask

  task automatic test_reset_mid_run;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (CC + 3) tick;
    #3 reset = 1'b1;
    #1;
    compared++;
    if ({st, signature, fail_count} !== '0) begin
      mismatched++;
      $display("FAIL async_reset: got %b/%h/%0d want all zero", st, signature, fail_count);
    end
    #1 reset = 1'b0;
    model_failcnt = 0;
    m_pass = 0; m_fail = 0; m_to = 0;
    run_session(8, GOLDEN, 0, 0);
  endtask

  initial begin
    test_reset;
    test_pass_and_fault;
    test_timeout;
    test_abort;
    test_start_during_run;
    test_random;
    test_saturation;
    test_reset_mid_run;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
